serial_comparator: RTL and testbench
====================================

Name: serial_comparator

Overview:
Parametrised sequential magnitude comparator. It compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, and supports both unsigned and two's-complement signed modes. A start/busy/done handshake controls each comparison, and the comparison exits early at the first differing digit. It is the multi-cycle, width-generic successor to our small combinational comparator, for datapaths where WIDTH is too wide for a single-cycle compare.

Parameters:
WIDTH, 8, operand width in bits; must be at least 2.
DIGIT, 2, bits examined per cycle; must divide WIDTH exactly. Violation is an elaboration-time error.
N (localparam), WIDTH/DIGIT, number of digits per operand.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request a comparison; accepted only while idle
a  input  WIDTH  operand A; sampled on the accepting edge only
b  input  WIDTH  operand B; sampled on the accepting edge only
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with the operands
busy  output  1  high while a comparison is in progress
done  output  1  one-cycle pulse when results update
equal  output  1  A == B (registered, held)
gt  output  1  A > B (registered, held)
lt  output  1  A < B (registered, held)

Behaviour:
- Reset (asynchronous, any time, including mid-comparison):
  - FSM goes to IDLE.
  - busy, done, equal, gt, lt all 0.
  - Digit index and operand registers cleared.
  - No partial result is produced.
- FSM states: IDLE and COMPARE.
- IDLE:
  - done is 0 unless it is the completion pulse from the previous cycle.
  - On an edge with start=1: latch a, b and signed_mode; set digit index k=0; busy=1; go to COMPARE.
  - equal/gt/lt keep their previous values until the next completion.
- COMPARE, each edge:
  - Compare digit N-1-k of the latched A against the same digit of latched B, as unsigned DIGIT-bit values.
  - In signed mode the operand MSB is inverted before the comparison on digit N-1 only. Resulting order is correct for two's complement.
  - Digits differ: gt or lt = 1 accordingly, the other two flags = 0; done=1; busy=0; go to IDLE.
  - Digits equal and k<N-1: k increments; stay in COMPARE.
  - Digits equal and k=N-1: equal=1, gt=0, lt=0; done=1; busy=0; go to IDLE.
- Latency from the accepting edge to done high is j+1 cycles, where j = position of the first differing digit counted from the MSB (0 = top digit). Equal operands take exactly N cycles.
- done is high for exactly one cycle per accepted start.
- After the first completion, equal/gt/lt are exactly one-hot. Before the first completion they are all 0.
- start while busy=1 is ignored. It is neither queued nor does it alter the comparison in flight.
- start is accepted in the same cycle that done is high (the FSM is already IDLE). Back-to-back comparisons have zero dead cycles.
- Changes on a, b or signed_mode after the accepting edge have no effect on the comparison in flight.
- DIGIT=WIDTH is legal: every comparison completes in 1 cycle.

Test Plan:
1. WIDTH=8, DIGIT=2, unsigned, a=0x5A, b=0x5A, start for one cycle -> busy high 4 cycles; done pulses on the 4th edge; equal=1, gt=0, lt=0.
2. a=0x80, b=0x7F -> unsigned: gt=1, done after 1 cycle. Repeat with signed_mode=1: lt=1 (-128 < 127), done after 1 cycle.
3. a=0x13, b=0x12, unsigned -> gt=1, done after 4 cycles. Then a=0x12, b=0x13 issued on the done cycle -> accepted immediately; lt=1 after 4 further cycles.
4. Start with a=0x40, b=0x41. Drive start=1 again and change a to 0xFF on the next 2 cycles -> second start ignored, operand change ignored; lt=1 after 4 cycles; exactly one done pulse.
5. Start a=0x00, b=0x01, assert rst after 2 cycles -> busy, done and all flags 0 immediately; FSM in IDLE. A new start after release completes normally.
6. Exhaustive sweep at WIDTH=3, DIGIT=1 and at WIDTH=4, DIGIT=2: every a,b pair in both modes -> flags match a behavioural reference compare; latency matches the first-differing-digit rule.

Source files
------------

// File: rtl/serial_comparator.sv
// serial_comparator: MSB-first multi-cycle magnitude compare, DIGIT bits per clock, unsigned or signed
module serial_comparator #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic             gt,
    output logic             lt
);
    localparam int N  = WIDTH / DIGIT;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 2 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_param_check
        $error("serial_comparator: WIDTH must be >= 2 and an exact multiple of DIGIT");
    end

    typedef enum logic {IDLE, COMPARE} state_t;

    state_t           r_state;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_a, r_b;
    logic             r_busy, r_done, r_equal, r_gt, r_lt;
    logic [DIGIT-1:0] w_da, w_db;

    // Operands shift left as digits match, so the digit under test is always on top
    assign w_da  = r_a[WIDTH-1 -: DIGIT];
    assign w_db  = r_b[WIDTH-1 -: DIGIT];
    assign busy  = r_busy;
    assign done  = r_done;
    assign equal = r_equal;
    assign gt    = r_gt;
    assign lt    = r_lt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_equal <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (start) begin
                    // Flipping the sign bit maps two's complement onto unsigned order
                    r_a     <= {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
                    r_b     <= {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};
                    r_k     <= '0;
                    r_busy  <= 1'b1;
                    r_state <= COMPARE;
                end
            end else if (w_da != w_db) begin
                r_equal <= 1'b0;
                r_gt    <= w_da > w_db;
                r_lt    <= w_da < w_db;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= IDLE;
            end else if (r_k == KW'(N - 1)) begin
                r_equal <= 1'b1;
                r_gt    <= 1'b0;
                r_lt    <= 1'b0;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= IDLE;
            end else begin
                r_k <= r_k + 1'b1;
                r_a <= r_a << DIGIT;
                r_b <= r_b << DIGIT;
            end
        end
    end
endmodule

// File: tb/tb_serial_comparator.sv
// tb_serial_comparator: random and directed checks of serial_comparator against an arithmetic model
module tb_serial_comparator;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       signed_mode = 1'b0;
    logic [4:0] o0, o1, o2, o3;
    int         n_assert = 0, n_fail = 0;

    always #5 clk = ~clk;

    serial_comparator #(.WIDTH(8), .DIGIT(2)) dut0 (.clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .signed_mode(signed_mode), .busy(o0[4]), .done(o0[3]), .equal(o0[2]), .gt(o0[1]), .lt(o0[0]));
    serial_comparator #(.WIDTH(3), .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .start(start), .a(a[2:0]), .b(b[2:0]),
        .signed_mode(signed_mode), .busy(o1[4]), .done(o1[3]), .equal(o1[2]), .gt(o1[1]), .lt(o1[0]));
    serial_comparator #(.WIDTH(4), .DIGIT(2)) dut2 (.clk(clk), .rst(rst), .start(start), .a(a[3:0]), .b(b[3:0]),
        .signed_mode(signed_mode), .busy(o2[4]), .done(o2[3]), .equal(o2[2]), .gt(o2[1]), .lt(o2[0]));
    serial_comparator #(.WIDTH(4), .DIGIT(4)) dut3 (.clk(clk), .rst(rst), .start(start), .a(a[3:0]), .b(b[3:0]),
        .signed_mode(signed_mode), .busy(o3[4]), .done(o3[3]), .equal(o3[2]), .gt(o3[1]), .lt(o3[0]));

    function automatic logic [4:0] st(input int s);
        return s == 0 ? o0 : s == 1 ? o1 : s == 2 ? o2 : o3;
    endfunction

    function automatic void model(input int w, input int d, input int x, input int y, input bit sm,
                                  output logic [2:0] f, output int lat);
        int sx = x, sy = y, n = w / d;
        if (sm && x >= (1 << (w - 1))) sx = x - (1 << w);
        if (sm && y >= (1 << (w - 1))) sy = y - (1 << w);
        f = sx == sy ? 3'b100 : sx > sy ? 3'b010 : 3'b001;
        lat = n;
        for (int i = n - 1; i >= 0; i--)
            if ((x >> (i * d)) != (y >> (i * d))) begin
                lat = n - i;
                break;
            end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input int x, input int y, input bit sm);
        start = 1'b1;
        a = 8'(x);
        b = 8'(y);
        signed_mode = sm;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_chk(input string tag, input int s, input int w, input int d,
                              input int x, input int y, input bit sm, input int cnt0);
        logic [2:0] f;
        int lat, cnt = cnt0;
        model(w, d, x, y, sm, f, lat);
        while (!st(s)[3] && cnt < 40) begin
            chk({tag, " busy"}, 32'(st(s)[4]), 1);
            @(negedge clk);
            cnt++;
        end
        chk({tag, " latency"}, cnt, lat);
        chk({tag, " flags"}, 32'(st(s)[2:0]), 32'(f));
        chk({tag, " busy at done"}, 32'(st(s)[4]), 0);
    endtask

    task automatic idle_chk(input string tag, input int s);
        logic [2:0] f = st(s)[2:0];
        @(negedge clk);
        chk({tag, " done pulse width"}, 32'(st(s)[3]), 0);
        chk({tag, " flags held"}, 32'(st(s)[2:0]), 32'(f));
    endtask

    initial begin
        int x, y, sm;
        @(negedge clk);
        for (int s = 0; s < 4; s++) chk($sformatf("reset outputs %0d", s), 32'(st(s)), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle before first start", 32'(o0), 0);

        launch(8'h5A, 8'h5A, 0);
        finish_chk("eq 5A", 0, 8, 2, 8'h5A, 8'h5A, 0, 0);
        chk("eq 5A exact flags", 32'(o0[2:0]), 3'b100);
        idle_chk("eq 5A", 0);
        launch(8'h80, 8'h7F, 0);
        finish_chk("80v7F unsigned", 0, 8, 2, 8'h80, 8'h7F, 0, 0);
        chk("80v7F unsigned gt", 32'(o0[2:0]), 3'b010);
        idle_chk("80v7F unsigned", 0);
        launch(8'h80, 8'h7F, 1);
        finish_chk("80v7F signed", 0, 8, 2, 8'h80, 8'h7F, 1, 0);
        chk("80v7F signed lt", 32'(o0[2:0]), 3'b001);
        idle_chk("80v7F signed", 0);

        launch(8'h13, 8'h12, 0);
        finish_chk("13v12", 0, 8, 2, 8'h13, 8'h12, 0, 0);
        launch(8'h12, 8'h13, 0);
        finish_chk("12v13 back-to-back", 0, 8, 2, 8'h12, 8'h13, 0, 0);
        chk("12v13 lt", 32'(o0[2:0]), 3'b001);
        idle_chk("12v13", 0);

        launch(8'h40, 8'h41, 0);
        start = 1'b1;
        a = 8'hFF;
        repeat (2) begin
            chk("busy ignores start", 32'(o0[4:3]), 2'b10);
            @(negedge clk);
        end
        start = 1'b0;
        finish_chk("40v41 with noise", 0, 8, 2, 8'h40, 8'h41, 0, 2);
        idle_chk("40v41", 0);

        launch(8'h00, 8'h01, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async reset outputs", 32'(o0), 0);
        @(negedge clk);
        chk("reset held outputs", 32'(o0), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle after reset", 32'(o0), 0);
        launch(8'h00, 8'h01, 0);
        finish_chk("00v01 after reset", 0, 8, 2, 8'h00, 8'h01, 0, 0);
        idle_chk("00v01", 0);

        for (int i = 0; i < 60; i++) begin
            x = $urandom_range(255);
            y = (i % 4 == 0) ? x : $urandom_range(255);
            sm = $urandom_range(1);
            launch(x, y, sm[0]);
            finish_chk($sformatf("w8 %0h %0h %0d", x, y, sm), 0, 8, 2, x, y, sm[0], 0);
        end
        idle_chk("w8 random", 0);

        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++) begin
                    launch(i, j, m[0]);
                    finish_chk($sformatf("w3 %0d %0d %0d", i, j, m), 1, 3, 1, i, j, m[0], 0);
                end
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < 16; j++) begin
                    launch(i, j, m[0]);
                    finish_chk($sformatf("w4 %0d %0d %0d", i, j, m), 2, 4, 2, i, j, m[0], 0);
                end
        idle_chk("w4 sweep", 2);

        for (int i = 0; i < 40; i++) begin
            x = $urandom_range(15);
            y = $urandom_range(15);
            sm = $urandom_range(1);
            launch(x, y, sm[0]);
            finish_chk($sformatf("w4d4 %0d %0d %0d", x, y, sm), 3, 4, 4, x, y, sm[0], 0);
        end
        idle_chk("w4d4", 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
